// File: rtl/excp_ctrl_pkg.sv
// Shared event codes, FSM encodings and the interrupt-request rule for the
// exception control stage in front of CP0.
package excp_ctrl_pkg;

    localparam logic [31:0] EXC_INT     = 32'h0000_0004;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
    localparam logic [31:0] EXC_ERET    = 32'h0000_0200;
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;

    localparam logic [1:0] EXS_IDLE     = 2'd0;
    localparam logic [1:0] EXS_REPORT   = 2'd1;
    localparam logic [1:0] EXS_FLUSH    = 2'd2;
    localparam logic [1:0] EXS_REDIRECT = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] code;
        logic [31:0] target;
    } excp_evt_t;

    // Interrupts are masked while EXL is set or IE is clear.
    function automatic logic int_request(input logic       ie,
                                         input logic       exl,
                                         input logic [5:0] im,
                                         input logic [5:0] ip,
                                         input logic       intimer);
        return ie & ~exl & ((|(ip & im)) | intimer);
    endfunction

endpackage

// File: rtl/excp_ctrl_if.sv
// MEM-stage / CP0 side bundle of the exception control stage.
interface excp_ctrl_if;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        is_syscall;
    logic        is_eret;
    logic [31:0] status;
    logic [31:0] cause;
    logic        intimer;
    logic [31:0] epc;

    logic [31:0] excptype;
    logic [31:0] excpc;
    logic        flush;
    logic        stall_fetch;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output inst_valid, inst_pc, is_syscall, is_eret, status, cause, intimer, epc,
        input  excptype, excpc, flush, stall_fetch, redirect, redirect_pc
    );

    modport slave (
        input  inst_valid, inst_pc, is_syscall, is_eret, status, cause, intimer, epc,
        output excptype, excpc, flush, stall_fetch, redirect, redirect_pc
    );
endinterface

// File: rtl/excp_ctrl_prio.sv
// Combinational event priority: interrupt > syscall > eret, with the
// redirect target each event will use.
module excp_ctrl_prio
    import excp_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic [31:0] status,
    input  logic [31:0] cause,
    input  logic        intimer,
    input  logic        is_syscall,
    input  logic        is_eret,
    input  logic [31:0] epc,
    output excp_evt_t   evt
);

    logic int_req_s;
    logic unused_s;

    assign int_req_s = int_request(status[0], status[1], status[15:10], cause[15:10], intimer);
    assign unused_s  = ^{status[31:16], status[9:2], cause[31:16], cause[9:0]};

    // Priority encode the candidate event and its target.
    always_comb begin
        evt = '{valid: 1'b0, code: EXC_NONE, target: 32'h0000_0000};
        if (int_req_s) begin
            evt = '{valid: 1'b1, code: EXC_INT, target: EXC_VECTOR};
        end else if (is_syscall) begin
            evt = '{valid: 1'b1, code: EXC_SYSCALL, target: EXC_VECTOR};
        end else if (is_eret) begin
            evt = '{valid: 1'b1, code: EXC_ERET, target: epc};
        end else begin
            evt = '{valid: 1'b0, code: EXC_NONE, target: 32'h0000_0000};
        end
    end

endmodule

// File: rtl/excp_ctrl.sv
// Exception/interrupt sequencer: one-cycle CP0 report, pipeline flush, then
// a single PC redirect to the handler vector or EPC.
module excp_ctrl
    import excp_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    excp_ctrl_if.slave  bus
);

    localparam logic [2:0] FLUSH_CNT_INIT = 3'(FLUSH_CYCLES - 1);

    excp_evt_t   evt_s;
    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;
    logic [31:0] excptype_q, excptype_d;
    logic [31:0] excpc_q, excpc_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    excp_ctrl_prio #(.EXC_VECTOR(EXC_VECTOR)) u_prio (
        .status     (bus.status),
        .cause      (bus.cause),
        .intimer    (bus.intimer),
        .is_syscall (bus.is_syscall),
        .is_eret    (bus.is_eret),
        .epc        (bus.epc),
        .evt        (evt_s)
    );

    // Next state and next registered outputs; outputs reflect the state being entered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        target_d      = target_q;
        excptype_d    = EXC_NONE;
        excpc_d       = 32'h0000_0000;
        flush_d       = 1'b0;
        stall_d       = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = 32'h0000_0000;
        case (state_q)
            EXS_IDLE: begin
                if (bus.inst_valid && evt_s.valid) begin
                    state_d    = EXS_REPORT;
                    cnt_d      = FLUSH_CNT_INIT;
                    target_d   = evt_s.target;
                    excptype_d = evt_s.code;
                    excpc_d    = bus.inst_pc;
                    flush_d    = 1'b1;
                    stall_d    = 1'b1;
                end else begin
                    state_d = EXS_IDLE;
                end
            end
            EXS_REPORT, EXS_FLUSH: begin
                // REPORT already counts as the first flush cycle.
                if (cnt_q == 3'd0) begin
                    state_d       = EXS_REDIRECT;
                    stall_d       = 1'b1;
                    redirect_d    = 1'b1;
                    redirect_pc_d = target_q;
                end else begin
                    state_d = EXS_FLUSH;
                    cnt_d   = cnt_q - 3'd1;
                    flush_d = 1'b1;
                    stall_d = 1'b1;
                end
            end
            EXS_REDIRECT: begin
                state_d = EXS_IDLE;
            end
            default: begin
                state_d = EXS_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State, latched target and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= EXS_IDLE;
            cnt_q         <= 3'd0;
            target_q      <= 32'h0000_0000;
            excptype_q    <= EXC_NONE;
            excpc_q       <= 32'h0000_0000;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            target_q      <= target_d;
            excptype_q    <= excptype_d;
            excpc_q       <= excpc_d;
            flush_q       <= flush_d;
            stall_q       <= stall_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.excptype    = excptype_q;
    assign bus.excpc       = excpc_q;
    assign bus.flush       = flush_q;
    assign bus.stall_fetch = stall_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;

endmodule
